// File: rtl/pll_lock_sequencer.sv
// PLL power-up/lock-loss sequencer on the free-running reference clock.
// Optional loss-of-lock counter is built when PLL_LOSS_COUNT_EN is defined.
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3,
  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
  input  logic          refclk,
  input  logic          rst_n,
  input  logic          pll_locked,
  input  logic          restart,
  output logic          pll_rst,
  output logic          sys_rst_n,
  output logic          ready,
  output logic          fail,
  output logic [RW-1:0] retry_cnt,
  output logic [7:0]    loss_cnt
);

  localparam int CMAX_A = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES
                                                                   : LOCK_STABLE_CYCLES;
  localparam int CMAX   = (CMAX_A > LOCK_TIMEOUT_CYCLES) ? CMAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CW     = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [RW-1:0] retry_d;
  logic          lock_meta, lock_s;

  // pll_locked is asynchronous to refclk
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    retry_d = retry_cnt;
    if (restart) begin
      state_d = S_RESET;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state)
        S_RESET: begin
          if (cnt == CW'(RST_PULSE_CYCLES - 1)) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            cnt_d = '0;
            if (retry_cnt < RW'(MAX_RETRIES)) begin
              retry_d = retry_cnt + RW'(1);
              state_d = S_RESET;
            end else begin
              state_d = S_FAIL;
            end
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
            state_d = S_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        S_RUN: begin
          retry_d = '0;
          if (!lock_s) begin
            state_d = S_RESET;
            cnt_d   = '0;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_RESET;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RESET;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      retry_cnt <= retry_d;
      pll_rst   <= (state_d == S_RESET);
      sys_rst_n <= (state_d == S_RUN);
      ready     <= (state_d == S_RUN);
      fail      <= (state_d == S_FAIL);
    end
  end

`ifdef PLL_LOSS_COUNT_EN
  logic loss_evt;
  assign loss_evt = (state == S_RUN) && !lock_s && !restart;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt <= 8'h00;
    end else if (loss_evt && (loss_cnt != 8'hFF)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end
`else
  assign loss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench: driver pushes expected output changes (edge number + value), monitor compares.
module tb_pll_lock_sequencer;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;

`ifdef PLL_LOSS_COUNT_EN
  localparam logic [7:0] LC1 = 8'd1;
  localparam logic [7:0] LC2 = 8'd2;
`else
  localparam logic [7:0] LC1 = 8'd0;
  localparam logic [7:0] LC2 = 8'd0;
`endif
  localparam int ANY = 65535;

  logic [29:0] exp_q[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES        (2)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt)
  );

  // clock / edge counter
  initial refclk = 1'b0;
  always #5 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  function automatic logic [13:0] pk(input logic pr, input logic srn, input logic rdy,
                                     input logic fl, input logic [1:0] rc, input logic [7:0] lc);
    return {pr, srn, rdy, fl, rc, lc};
  endfunction

  task automatic ex(input int c, input logic [13:0] v);
    logic [15:0] c16;
    c16 = c[15:0];
    exp_q.push_back({c16, v});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  // monitor: every change of the output vector consumes one expected entry
  initial begin
    logic [13:0] prev, cur;
    logic [29:0] e;
    prev = 'x;
    forever begin
      @(negedge refclk);
      cur = {pll_rst, sys_rst_n, ready, fail, retry_cnt, loss_cnt};
      if (cur !== prev) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change edge=%0d got=%b", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          if (((e[29:14] != 16'hFFFF) && (e[29:14] != cyc[15:0])) || (e[13:0] !== cur)) begin
            n_bad++;
            $display("FAIL output_change got edge=%0d val=%b, want edge=%0d val=%b",
                     cyc, cur, e[29:14], e[13:0]);
          end
        end
        prev = cur;
      end
    end
  end

  // driver
  initial begin
    int r, c, d, e, f, h;
    rst_n      = 1'b1;
    pll_locked = 1'b0;
    restart    = 1'b0;
    ex(ANY, pk(1, 0, 0, 0, 2'd0, 8'd0));
    #1 rst_n = 1'b0;
    step(3);

    // nominal bring-up: lock seen before edge 20 after release -> RUN at edge 30
    r = cyc;
    rst_n = 1'b1;
    ex(r + 4,  pk(0, 0, 0, 0, 2'd0, 8'd0));
    ex(r + 30, pk(0, 1, 1, 0, 2'd0, 8'd0));
    wait_until(r + 19);
    pll_locked = 1'b1;

    // loss of lock in RUN
    wait_until(r + 35);
    c = cyc;
    pll_locked = 1'b0;
    ex(c + 3, pk(1, 0, 0, 0, 2'd0, LC1));
    ex(c + 7, pk(0, 0, 0, 0, 2'd0, LC1));

    // glitch during STABLE: 5 high, 1 low, then high
    wait_until(c + 8);
    d = cyc;
    pll_locked = 1'b1;
    wait_until(d + 5);
    pll_locked = 1'b0;
    wait_until(d + 6);
    pll_locked = 1'b1;
    ex(d + 17, pk(0, 1, 1, 0, 2'd0, LC1));

    // second loss, then restart on the edge STABLE completes
    wait_until(d + 20);
    e = cyc;
    pll_locked = 1'b0;
    ex(e + 3, pk(1, 0, 0, 0, 2'd0, LC2));
    ex(e + 7, pk(0, 0, 0, 0, 2'd0, LC2));
    wait_until(e + 7);
    f = cyc;
    pll_locked = 1'b1;
    ex(f + 11, pk(1, 0, 0, 0, 2'd0, LC2));
    ex(f + 15, pk(0, 0, 0, 0, 2'd0, LC2));
    ex(f + 24, pk(0, 1, 1, 0, 2'd0, LC2));
    wait_until(f + 10);
    restart = 1'b1;
    step(1);
    restart = 1'b0;

    // async reset mid-RUN, between edges
    wait_until(f + 26);
    ex(f + 26, pk(1, 0, 0, 0, 2'd0, 8'd0));
    rst_n = 1'b0;
    pll_locked = 1'b0;
    step(2);

    // timeouts, retries and FAIL, then restart
    h = cyc;
    rst_n = 1'b1;
    ex(h + 4,   pk(0, 0, 0, 0, 2'd0, 8'd0));
    ex(h + 36,  pk(1, 0, 0, 0, 2'd1, 8'd0));
    ex(h + 40,  pk(0, 0, 0, 0, 2'd1, 8'd0));
    ex(h + 72,  pk(1, 0, 0, 0, 2'd2, 8'd0));
    ex(h + 76,  pk(0, 0, 0, 0, 2'd2, 8'd0));
    ex(h + 108, pk(0, 0, 0, 1, 2'd2, 8'd0));
    ex(h + 116, pk(1, 0, 0, 0, 2'd0, 8'd0));
    ex(h + 120, pk(0, 0, 0, 0, 2'd0, 8'd0));
    wait_until(h + 115);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    wait_until(h + 130);

    // final report
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_expected got=%0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
